// File: rtl/ch375_pkg.sv
// rtl/ch375_pkg.sv - register map, status bits, frame constants and FSM state types for the CH375 device UART
package ch375_pkg;

    localparam logic [2:0] REG_DATA = 3'd0;
    localparam logic [2:0] REG_STAT = 3'd1;
    localparam logic [2:0] REG_TX   = 3'd2;
    localparam logic [2:0] REG_NINT = 3'd3;

    localparam int ST_RX_NONEMPTY = 24;
    localparam int ST_TX_FULL     = 25;
    localparam int ST_RX_OVF      = 26;
    localparam int ST_TX_IDLE     = 27;
    localparam int ST_FRAME_ERR   = 28;

    localparam int   FRAME_BITS = 11;
    localparam int   OVERSAMPLE = 16;
    localparam logic TAG_CMD    = 1'b1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

endpackage

// File: rtl/ch375_dev_uart_if.sv
// rtl/ch375_dev_uart_if.sv - pCPU peripheral bus: word address, write data/strobe, combinational read data
interface ch375_dev_uart_if;
    logic [2:0]  a;
    logic [31:0] d;
    logic        we;
    logic [31:0] spo;

    modport master (output a, d, we, input spo);
    modport slave  (input a, d, we, output spo);
endinterface

// File: rtl/ch375_dev_uart_sync_fifo.sv
// rtl/ch375_dev_uart_sync_fifo.sv - first-word-fall-through FIFO; push while full is accepted only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/ch375_dev_uart.sv
// rtl/ch375_dev_uart.sv - device-side CH375 9-bit serial link with tagged RX/TX FIFOs and host nint line
module ch375_dev_uart
    import ch375_pkg::*;
#(
    parameter int CLK_HZ     = 62500000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    ch375_dev_uart_if.slave   bus,
    output logic              irq,
    input  logic              ser_rx,
    output logic              ser_tx,
    output logic              nint
);
    localparam int TICK_DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          wr_data, wr_stat, wr_tx, wr_nint;
    logic          rx_full, rx_empty, rx_push, rx_ferr;
    logic [8:0]    rx_head;
    logic          tx_full, tx_empty, tx_pop, tx_idle;
    logic [8:0]    tx_head;
    logic          frame_err, rx_ovf;
    logic          unused_d;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) tick_cnt <= '0;
        else             tick_cnt <= tick_cnt + 1'b1;
    end

    assign wr_data  = bus.we && (bus.a == REG_DATA);
    assign wr_stat  = bus.we && (bus.a == REG_STAT);
    assign wr_tx    = bus.we && (bus.a == REG_TX);
    assign wr_nint  = bus.we && (bus.a == REG_NINT);
    assign unused_d = ^bus.d[22:0];

    // ---------------- receive ----------------
    logic       rx_s1, rx_s2;
    rx_state_t  rx_state, rx_next;
    logic [3:0] rx_phase, rx_nbits;
    logic [8:0] rx_sh;
    logic       rx_mid;

    always_ff @(posedge clk) begin
        if (rst) {rx_s1, rx_s2} <= 2'b11;
        else     {rx_s1, rx_s2} <= {ser_rx, rx_s1};
    end

    // START checks the line half a bit in; every later sample is a full bit apart
    assign rx_mid = tick && (rx_phase == ((rx_state == RX_START) ? 4'd7 : 4'd15));

    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_s2) rx_next = RX_START;
            RX_START: if (rx_mid) rx_next = rx_s2 ? RX_IDLE : RX_BITS;
            RX_BITS:  if (rx_mid && rx_nbits == 4'd8) rx_next = RX_STOP;
            RX_STOP:  if (rx_mid) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_push = 1'b0;
        rx_ferr = 1'b0;
        if (rx_state == RX_STOP && rx_mid) begin
            rx_push = rx_s2;
            rx_ferr = !rx_s2;
        end
    end

    assign irq = rx_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_phase <= '0;
            rx_nbits <= '0;
            rx_sh    <= '0;
        end else if (rx_state == RX_IDLE) begin
            rx_phase <= '0;
            rx_nbits <= '0;
        end else if (tick) begin
            if (rx_mid) begin
                rx_phase <= '0;
                if (rx_state == RX_BITS) begin
                    rx_sh    <= {rx_s2, rx_sh[8:1]};
                    rx_nbits <= rx_nbits + 1'b1;
                end
            end else begin
                rx_phase <= rx_phase + 1'b1;
            end
        end
    end

    sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst),
        .push(rx_push), .push_data(rx_sh), .pop(wr_data),
        .full(rx_full), .empty(rx_empty), .head(rx_head)
    );

    // a bus pop in the same cycle frees the slot, so that push is not an overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            rx_ovf    <= 1'b0;
        end else begin
            if (rx_ferr)                              frame_err <= 1'b1;
            else if (wr_stat && bus.d[ST_FRAME_ERR])  frame_err <= 1'b0;
            if (rx_push && rx_full && !wr_data)       rx_ovf <= 1'b1;
            else if (wr_stat && bus.d[ST_RX_OVF])     rx_ovf <= 1'b0;
        end
    end

    // ---------------- transmit ----------------
    tx_state_t             tx_state, tx_next;
    logic [3:0]            tx_phase, tx_nbits;
    logic [FRAME_BITS-1:0] tx_sh;
    logic                  tx_line, tx_edge;

    assign tx_edge = tick && (tx_phase == 4'd15);

    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (!tx_empty) tx_next = TX_SHIFT;
            TX_SHIFT: if (tx_edge && tx_nbits == 4'(FRAME_BITS)) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_pop = (tx_state == TX_IDLE) && !tx_empty;
    end

    // phase is preloaded to 15 so the start bit goes out on the very next tick
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_line  <= 1'b1;
            tx_phase <= '0;
            tx_nbits <= '0;
            tx_sh    <= '1;
        end else if (tx_pop) begin
            tx_sh    <= {1'b1, tx_head[8], tx_head[7:0], 1'b0};
            tx_phase <= 4'd15;
            tx_nbits <= '0;
        end else if (tx_state == TX_SHIFT && tick) begin
            if (tx_edge) begin
                tx_phase <= '0;
                if (tx_nbits != 4'(FRAME_BITS)) begin
                    tx_line  <= tx_sh[0];
                    tx_sh    <= {1'b1, tx_sh[FRAME_BITS-1:1]};
                    tx_nbits <= tx_nbits + 1'b1;
                end
            end else begin
                tx_phase <= tx_phase + 1'b1;
            end
        end
    end

    assign ser_tx  = tx_line;
    assign tx_idle = tx_empty && (tx_state == TX_IDLE);

    sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst),
        .push(wr_tx), .push_data({bus.d[23] == TAG_CMD, bus.d[31:24]}), .pop(tx_pop),
        .full(tx_full), .empty(tx_empty), .head(tx_head)
    );

    // ---------------- host interrupt and read mux ----------------
    always_ff @(posedge clk) begin
        if (rst)          nint <= 1'b1;
        else if (wr_nint) nint <= bus.d[24];
    end

    always_comb begin
        bus.spo = '0;
        case (bus.a)
            REG_DATA: if (!rx_empty) bus.spo = {rx_head[7:0], 7'b0, rx_head[8], 16'b0};
            REG_STAT: begin
                bus.spo[ST_FRAME_ERR]   = frame_err;
                bus.spo[ST_TX_IDLE]     = tx_idle;
                bus.spo[ST_RX_OVF]      = rx_ovf;
                bus.spo[ST_TX_FULL]     = tx_full;
                bus.spo[ST_RX_NONEMPTY] = !rx_empty;
            end
            REG_NINT: bus.spo[24] = nint;
            default:  bus.spo = '0;
        endcase
    end
endmodule

// File: tb/tb_ch375_dev_uart.sv
// tb/tb_ch375_dev_uart.sv - directed scoreboard bench for ch375_dev_uart at 10 clk/tick, 160 clk/bit
module tb_ch375_dev_uart;
    import ch375_pkg::*;

    localparam int CLK_HZ     = 1600000;
    localparam int BAUD       = 10000;
    localparam int FIFO_DEPTH = 8;
    localparam int BIT_CLK    = 160;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ser_rx = 1'b1;
    logic irq, ser_tx, nint;

    ch375_dev_uart_if bus();

    ch375_dev_uart #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus), .irq(irq),
        .ser_rx(ser_rx), .ser_tx(ser_tx), .nint(nint)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int irq_cnt = 0;
    int cyc = 0;

    logic [31:0] rx_exp[$];
    logic [9:0]  tx_exp[$];
    logic [9:0]  tx_got[$];
    int          tx_start[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (irq === 1'b1) irq_cnt = irq_cnt + 1;

    // host-side receiver: decodes {stop, tag, data} from ser_tx, sampling mid-bit
    initial begin
        logic [9:0] fr;
        int         t;
        forever begin
            @(negedge clk);
            if (!rst && ser_tx === 1'b0) begin
                t = cyc;
                repeat (BIT_CLK/2 - 1) @(negedge clk);
                if (ser_tx === 1'b0) begin
                    tx_start.push_back(t);
                    for (int j = 0; j < 10; j++) begin
                        repeat (BIT_CLK) @(negedge clk);
                        fr[j] = ser_tx;
                    end
                    tx_got.push_back(fr);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time limit, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.a = addr; bus.d = data; bus.we = 1'b1;
        @(negedge clk);
        bus.we = 1'b0; bus.d = '0; bus.a = '0;
    endtask

    task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus.a = addr;
        #1 data = bus.spo;
    endtask

    // bad-stop frames release the line early so the stop-bit low is not taken as a new start
    task automatic send_frame(input logic [7:0] data, input logic tag, input logic stop);
        logic [9:0] bits;
        bits = {tag, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            ser_rx = bits[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        ser_rx = stop;
        repeat (stop ? BIT_CLK : 110) @(negedge clk);
        ser_rx = 1'b1;
        repeat (stop ? 40 : 100) @(negedge clk);
    endtask

    task automatic rx_read_pop(input string tag);
        logic [31:0] v, e;
        bus_read(REG_DATA, v);
        e = (rx_exp.size() == 0) ? 32'h0 : rx_exp.pop_front();
        chk(tag, v, e);
        bus_write(REG_DATA, 32'h0);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k;
        k = 0;
        while (tx_got.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("tx_frame_count", 32'(tx_got.size()), 32'(n));
    endtask

    task automatic check_tx_frames(input string tag);
        while (tx_got.size() > 0 && tx_exp.size() > 0)
            chk(tag, 32'(tx_got.pop_front()), 32'(tx_exp.pop_front()));
    endtask

    initial begin
        logic [31:0] v;
        logic [7:0]  b;
        int          i0, k, low_len, high_len, gap;

        bus.a = '0; bus.d = '0; bus.we = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ser_tx", 32'(ser_tx), 32'd1);
        chk("rst_nint", 32'(nint), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        bus_read(REG_STAT, v);
        chk("rst_status", v, 32'h0800_0000);
        bus_read(REG_DATA, v);
        chk("rst_data", v, 32'h0);

        // single command frame from host
        i0 = irq_cnt;
        send_frame(8'hA5, 1'b1, 1'b1);
        rx_exp.push_back(32'hA501_0000);
        chk("rx1_irq_pulses", 32'(irq_cnt - i0), 32'd1);
        bus_read(REG_STAT, v);
        chk("rx1_nonempty", 32'(v[24]), 32'd1);
        rx_read_pop("rx1_data");
        bus_read(REG_STAT, v);
        chk("rx1_empty_after_pop", 32'(v[24]), 32'd0);

        // single data frame to host
        tx_got.delete(); tx_start.delete();
        tx_exp.push_back({1'b1, 1'b0, 8'h3C});
        bus_write(REG_TX, 32'h3C00_0000);
        bus_read(REG_STAT, v);
        chk("tx_busy", 32'(v[27]), 32'd0);
        k = 0;
        while (ser_tx !== 1'b0 && k < 500) begin @(negedge clk); k++; end
        low_len = 0;
        while (ser_tx === 1'b0 && low_len < 2000) begin @(negedge clk); low_len++; end
        high_len = 0;
        while (ser_tx === 1'b1 && high_len < 2000) begin @(negedge clk); high_len++; end
        chk("tx_start_d0_d1_width", 32'(low_len), 32'd480);
        chk("tx_d2_d5_width", 32'(high_len), 32'd640);
        wait_tx(1, 3000);
        check_tx_frames("tx_3c_frame");
        repeat (200) @(negedge clk);
        bus_read(REG_STAT, v);
        chk("tx_idle_after_frame", v, 32'h0800_0000);

        // overflow: FIFO_DEPTH+1 frames without popping
        i0 = irq_cnt;
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            b = 8'(8'h10 + i * 17);
            send_frame(b, i[0], 1'b1);
            if (i < FIFO_DEPTH) rx_exp.push_back({b, 7'b0, i[0], 16'b0});
        end
        chk("ovf_irq_pulses", 32'(irq_cnt - i0), 32'(FIFO_DEPTH + 1));
        bus_read(REG_STAT, v);
        chk("ovf_status", v, 32'h0D00_0000);
        bus_write(REG_STAT, 32'h0400_0000);
        bus_read(REG_STAT, v);
        chk("ovf_cleared", v, 32'h0900_0000);
        for (int i = 0; i < FIFO_DEPTH; i++) rx_read_pop("ovf_data");
        bus_read(REG_STAT, v);
        chk("ovf_drained", v, 32'h0800_0000);

        // bad stop bit, then a short glitch
        i0 = irq_cnt;
        send_frame(8'h77, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        chk("ferr_no_irq", 32'(irq_cnt - i0), 32'd0);
        bus_read(REG_STAT, v);
        chk("ferr_status", v, 32'h1800_0000);
        bus_read(REG_DATA, v);
        chk("ferr_fifo_empty", v, 32'h0);
        bus_write(REG_STAT, 32'h1000_0000);
        bus_read(REG_STAT, v);
        chk("ferr_cleared", v, 32'h0800_0000);
        i0 = irq_cnt;
        @(negedge clk); ser_rx = 1'b0;
        repeat (40) @(negedge clk); ser_rx = 1'b1;
        repeat (400) @(negedge clk);
        chk("glitch_no_irq", 32'(irq_cnt - i0), 32'd0);
        bus_read(REG_STAT, v);
        chk("glitch_status", v, 32'h0800_0000);

        // nint control
        bus_write(REG_NINT, 32'h0);
        chk("nint_low", 32'(nint), 32'd0);
        bus_read(REG_NINT, v);
        chk("nint_read_low", v, 32'h0);
        bus_write(REG_NINT, 32'h0100_0000);
        chk("nint_high", 32'(nint), 32'd1);
        bus_read(REG_NINT, v);
        chk("nint_read_high", v, 32'h0100_0000);
        bus_write(REG_NINT, 32'h0);

        // reset in the middle of a TX frame with another byte queued
        bus_write(REG_TX, 32'h5500_0000);
        bus_write(REG_TX, 32'h6680_0000);
        repeat (400) @(negedge clk);
        k = 0;
        while (ser_tx !== 1'b0 && k < 500) begin @(negedge clk); k++; end
        chk("pre_rst_line_low", 32'(ser_tx), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midtx_rst_ser_tx", 32'(ser_tx), 32'd1);
        chk("midtx_rst_nint", 32'(nint), 32'd1);
        bus_read(REG_STAT, v);
        chk("midtx_rst_status", v, 32'h0800_0000);
        repeat (2000) @(negedge clk);
        tx_got.delete(); tx_start.delete(); tx_exp.delete();

        // burst: one goes straight to the shifter, eight fill the FIFO, the last is dropped
        @(negedge clk);
        for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
            b = 8'(8'hC0 + i);
            bus.a = REG_TX; bus.d = {b, i[0], 23'b0}; bus.we = 1'b1;
            if (i < FIFO_DEPTH + 1) tx_exp.push_back({1'b1, i[0], b});
            @(negedge clk);
        end
        bus.we = 1'b0; bus.a = '0; bus.d = '0;
        bus_read(REG_STAT, v);
        chk("burst_tx_full", 32'(v[25]), 32'd1);
        wait_tx(FIFO_DEPTH + 1, (FIFO_DEPTH + 2) * 1800);
        for (int i = 0; i + 1 < tx_start.size(); i++) begin
            gap = tx_start[i+1] - tx_start[i];
            chk("burst_contiguous", 32'(gap >= 1760 && gap <= 1770), 32'd1);
        end
        check_tx_frames("burst_frame");
        repeat (2000) @(negedge clk);
        chk("burst_no_extra_frame", 32'(tx_got.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
